gpio_iosim_chardev: RTL and testbench

GPIO_IOSIM_CHARDEV -- requirements
Module: gpio_iosim_chardev

---
 rtl/gpio_iosim_chardev.sv | 158 +++++++++++++++
 tb/tb_gpio_iosim_chardev.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/gpio_iosim_chardev.sv
// Simulated GPIO character device: a register window onto a TX console FIFO
// and an RX stimulus FIFO, with sticky error flags and a scratch byte.

// Byte FIFO with flush. Accept decisions use start-of-cycle full/empty.
module gpio_iosim_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic       i_flush,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic [7:0] o_count,
  output logic       o_full,
  output logic       o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          w_do_push, w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full && !i_flush;
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign o_data    = o_empty ? 8'h00 : r_mem[r_rptr];
  assign o_count   = 8'(r_count);

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  // Pointers wrap naturally (power-of-two depth); flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module gpio_iosim_chardev #(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        write,
  input  logic        read,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready
);
  localparam logic [5:0]  A_TXDATA  = 6'h00;
  localparam logic [5:0]  A_RXDATA  = 6'h01;
  localparam logic [5:0]  A_STATUS  = 6'h02;
  localparam logic [5:0]  A_CTRL    = 6'h03;
  localparam logic [5:0]  A_SCRATCH = 6'h04;
  localparam logic [5:0]  A_ID      = 6'h05;
  localparam logic [31:0] ID_VALUE  = 32'h494F_5331;

  logic [5:0]  w_addr;
  logic        w_tx_wr, w_rx_rd, w_ctrl_wr, w_scr_wr;
  logic        w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic [7:0]  w_tx_count, w_rx_count, w_rx_head;
  logic [31:0] w_status, w_rd_mux;
  logic        w_unused;
  logic        r_tx_ovf, r_rx_udf;
  logic [7:0]  r_scratch;

  assign w_addr    = addr[5:0];
  assign w_unused  = ^{addr[31:6], wdata[31:8]};
  assign w_tx_wr   = write && (w_addr == A_TXDATA);
  assign w_ctrl_wr = write && (w_addr == A_CTRL);
  assign w_scr_wr  = write && (w_addr == A_SCRATCH);
  assign w_rx_rd   = read  && (w_addr == A_RXDATA);

  gpio_iosim_fifo #(.DEPTH(TX_DEPTH)) u_tx (
    .clk(clk), .rst(rst),
    .i_push(w_tx_wr), .i_pop(tx_valid && tx_ready),
    .i_flush(w_ctrl_wr && wdata[1]), .i_data(wdata[7:0]),
    .o_data(tx_data), .o_count(w_tx_count),
    .o_full(w_tx_full), .o_empty(w_tx_empty)
  );

  gpio_iosim_fifo #(.DEPTH(RX_DEPTH)) u_rx (
    .clk(clk), .rst(rst),
    .i_push(rx_valid), .i_pop(w_rx_rd),
    .i_flush(w_ctrl_wr && wdata[2]), .i_data(rx_data),
    .o_data(w_rx_head), .o_count(w_rx_count),
    .o_full(w_rx_full), .o_empty(w_rx_empty)
  );

  assign tx_valid = !w_tx_empty;
  assign rx_ready = !w_rx_full;

  assign w_status = {8'h00, w_rx_count, w_tx_count,
                     2'b00, r_rx_udf, r_tx_ovf,
                     w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};

  // Read mux; write-only and unmapped addresses read as zero.
  always_comb begin
    w_rd_mux = 32'h0;
    case (w_addr)
      A_RXDATA:  w_rd_mux = {24'h0, w_rx_head};
      A_STATUS:  w_rd_mux = w_status;
      A_SCRATCH: w_rd_mux = {24'h0, r_scratch};
      A_ID:      w_rd_mux = ID_VALUE;
      default:   w_rd_mux = 32'h0;
    endcase
  end

  // Registered read data, held between read strobes.
  always_ff @(posedge clk) begin
    if (rst)       rdata <= 32'h0;
    else if (read) rdata <= w_rd_mux;
  end

  // Sticky flags: a same-cycle set outranks a CTRL clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_ovf <= 1'b0;
      r_rx_udf <= 1'b0;
    end else begin
      r_tx_ovf <= (w_tx_wr && w_tx_full) ||
                  (r_tx_ovf && !(w_ctrl_wr && wdata[0]));
      r_rx_udf <= (w_rx_rd && w_rx_empty) ||
                  (r_rx_udf && !(w_ctrl_wr && wdata[0]));
    end
  end

  // Scratch byte.
  always_ff @(posedge clk) begin
    if (rst)           r_scratch <= 8'h00;
    else if (w_scr_wr) r_scratch <= wdata[7:0];
  end
endmodule

// File: tb/tb_gpio_iosim_chardev.sv
// Directed bench for gpio_iosim_chardev with hand-computed expectations.
module tb_gpio_iosim_chardev;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        write, read;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;

  int checks = 0;
  int errors = 0;

  gpio_iosim_chardev #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .addr(addr), .write(write), .read(read),
    .wdata(wdata), .rdata(rdata), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a);
    addr = a; read = 1'b1;
    tick();
    read = 1'b0;
  endtask

  initial begin
    rst = 1'b1; addr = '0; write = 1'b0; read = 1'b0; wdata = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    chk("rst_rx_ready", {31'h0, rx_ready}, 32'h1);

    do_read(32'h5);  chk("id", rdata, 32'h494F_5331);
    do_read(32'h2);  chk("status_idle", rdata, 32'h0000_000A);
    do_read(32'hFFFF_FFC5); chk("id_hi_addr_ignored", rdata, 32'h494F_5331);
    do_read(32'h6);  chk("unmapped_rd", rdata, 32'h0);
    do_read(32'h0);  chk("txdata_rd_zero", rdata, 32'h0);
    do_read(32'h3);  chk("ctrl_rd_zero", rdata, 32'h0);
    // rdata holds with no read strobe
    tick(); chk("rdata_hold", rdata, 32'h0);

    do_write(32'h4, 32'h1234_56A5);
    do_read(32'h4);  chk("scratch", rdata, 32'h0000_00A5);
    do_write(32'h5, 32'hFFFF_FFFF);   // write to read-only ID ignored
    do_read(32'h5);  chk("id_ro", rdata, 32'h494F_5331);

    // Same-cycle write and read of SCRATCH: read sees old value
    addr = 32'h4; wdata = 32'h3C; write = 1'b1; read = 1'b1;
    tick();
    write = 1'b0; read = 1'b0;
    chk("scratch_wr_rd_old", rdata, 32'h0000_00A5);
    do_read(32'h4);  chk("scratch_new", rdata, 32'h0000_003C);

    // TX overflow: 17 writes into a 16-deep FIFO
    tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) do_write(32'h0, 32'h41 + i);
    chk("tx_full_valid", {31'h0, tx_valid}, 32'h1);
    do_read(32'h2);  chk("status_tx_full", rdata, 32'h0000_1019);
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("tx_drain", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'(8'h41 + i)});
      tick();
    end
    tx_ready = 1'b0;
    chk("tx_drained_valid", {31'h0, tx_valid}, 32'h0);
    chk("tx_drained_data", {24'h0, tx_data}, 32'h0);
    do_read(32'h2);  chk("status_ovf_sticky", rdata, 32'h0000_001A);
    do_write(32'h3, 32'h1);
    do_read(32'h2);  chk("status_ovf_clr", rdata, 32'h0000_000A);

    // RX basic and underflow
    rx_valid = 1'b1; rx_data = 8'h10; tick();
    rx_data = 8'h20; tick();
    rx_valid = 1'b0;
    do_read(32'h1);  chk("rx_b0", rdata, 32'h10);
    do_read(32'h1);  chk("rx_b1", rdata, 32'h20);
    do_read(32'h1);  chk("rx_udf_data", rdata, 32'h0);
    do_read(32'h2);  chk("status_udf", rdata, 32'h0000_002A);
    do_write(32'h3, 32'h1);
    do_read(32'h2);  chk("status_udf_clr", rdata, 32'h0000_000A);

    // RX full, pop with concurrent offer
    rx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rx_data = 8'h80 + 8'(i);
      tick();
    end
    rx_valid = 1'b0;
    chk("rx_full_ready", {31'h0, rx_ready}, 32'h0);
    do_read(32'h2);  chk("status_rx_full", rdata, 32'h0010_0006);
    rx_valid = 1'b1; rx_data = 8'hEE;
    addr = 32'h1; read = 1'b1;
    tick();
    read = 1'b0;
    chk("rx_pop_when_full", rdata, 32'h80);
    chk("rx_ready_after_pop", {31'h0, rx_ready}, 32'h1);
    tick();
    rx_valid = 1'b0;
    chk("rx_refull_ready", {31'h0, rx_ready}, 32'h0);
    for (int i = 1; i < 16; i++) begin
      do_read(32'h1);
      chk("rx_drain", rdata, 32'h80 + i);
    end
    do_read(32'h1);  chk("rx_late_push", rdata, 32'hEE);
    do_read(32'h2);  chk("status_rx_empty", rdata, 32'h0000_000A);

    // TX flush concurrent with handshake
    for (int i = 0; i < 5; i++) do_write(32'h0, 32'h61 + i);
    do_read(32'h2);  chk("status_tx5", rdata, 32'h0000_0508);
    tx_ready = 1'b1;
    do_write(32'h3, 32'h2);
    tx_ready = 1'b0;
    chk("flush_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("flush_tx_data", {24'h0, tx_data}, 32'h0);
    do_read(32'h2);  chk("status_flushed", rdata, 32'h0000_000A);

    // Simultaneous push and pop keeps count
    do_write(32'h0, 32'h71);
    do_write(32'h0, 32'h72);
    tx_ready = 1'b1;
    do_write(32'h0, 32'h73);
    tx_ready = 1'b0;
    chk("pushpop_head", {24'h0, tx_data}, 32'h72);
    do_read(32'h2);  chk("status_pushpop", rdata, 32'h0000_0208);

    // RX flush
    rx_valid = 1'b1; rx_data = 8'h55; tick(); rx_valid = 1'b0;
    do_write(32'h3, 32'h4);
    do_read(32'h2);  chk("status_rx_flush", rdata, 32'h0000_0208);

    // Reset mid-stream with in-flight read strobe
    do_write(32'h4, 32'hA5);
    rx_valid = 1'b1; rx_data = 8'h99; tick(); rx_valid = 1'b0;
    rst = 1'b1; addr = 32'h5; read = 1'b1;
    tick();
    rst = 1'b0; read = 1'b0;
    chk("midrst_rdata", rdata, 32'h0);
    chk("midrst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("midrst_rx_ready", {31'h0, rx_ready}, 32'h1);
    do_read(32'h4);  chk("midrst_scratch", rdata, 32'h0);
    do_read(32'h2);  chk("midrst_status", rdata, 32'h0000_000A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
